tea_decrypt: RTL and testbench

//   Iterative TEA block decryptor: one 64-bit ciphertext block and a 128-bit key in, one plaintext block out.

---
 rtl/tea_pkg.sv | 23 ++
 rtl/tea_round_dec.sv | 19 +
 rtl/tea_decrypt.sv | 91 +++++++++
 tb/tb_tea_decrypt.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/tea_pkg.sv
// Shared TEA definitions: constants, FSM state encoding, key layout and round function.
package tea_pkg;

  localparam logic [31:0] TEA_DELTA      = 32'h9E3779B9;
  localparam int          TEA_ROUNDS_DEF = 32;
  localparam logic [31:0] TEA_SUM_INIT   = 32'(TEA_DELTA * TEA_ROUNDS_DEF);

  typedef enum logic [1:0] {IDLE, RUN, DONE} tea_state_e;

  // k0 sits in the top word so a plain cast from the 128-bit port works
  typedef struct packed {
    logic [31:0] k0;
    logic [31:0] k1;
    logic [31:0] k2;
    logic [31:0] k3;
  } tea_key_t;

  function automatic logic [31:0] tea_f(input logic [31:0] v, input logic [31:0] sum,
                                        input logic [31:0] ka, input logic [31:0] kb);
    return ((v << 4) + ka) ^ (v + sum) ^ ((v >> 5) + kb);
  endfunction

endpackage

// File: rtl/tea_round_dec.sv
// One full TEA decryption round, purely combinational; v0 update consumes the new v1.
module tea_round_dec
  import tea_pkg::*;
(
  input  logic [31:0] v0,
  input  logic [31:0] v1,
  input  logic [31:0] sum,
  input  tea_key_t    key,
  output logic [31:0] v0_n,
  output logic [31:0] v1_n
);

  // two chained half-rounds: undo v1 first, then v0 with the recovered v1
  always_comb begin
    v1_n = v1 - tea_f(v0, sum, key.k2, key.k3);
    v0_n = v0 - tea_f(v1_n, sum, key.k0, key.k1);
  end

endmodule

// File: rtl/tea_decrypt.sv
// Iterative TEA decryptor: one round per clock, start/busy/done handshake.
module tea_decrypt
  import tea_pkg::*;
#(
  parameter int          ROUNDS = TEA_ROUNDS_DEF,
  parameter logic [31:0] DELTA  = TEA_DELTA
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [63:0]  ciphertext,
  input  logic [127:0] key,
  output logic [63:0]  plaintext,
  output logic         busy,
  output logic         done
);

  localparam int          CW       = $clog2(ROUNDS + 1);
  localparam logic [31:0] SUM_INIT = 32'(DELTA * ROUNDS);

  tea_state_e  state, state_n;
  logic [31:0] v0, v1, sum;
  logic [31:0] v0_n, v1_n;
  tea_key_t    key_q;
  logic [CW-1:0] round_cnt;
  logic        accept, last;

  assign accept = start && (state == IDLE || state == DONE);
  assign last   = (round_cnt == CW'(ROUNDS - 1));

  tea_round_dec u_round (
    .v0   (v0),
    .v1   (v1),
    .sum  (sum),
    .key  (key_q),
    .v0_n (v0_n),
    .v1_n (v1_n)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // next-state: DONE re-enters RUN directly when start is already waiting
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (last)  state_n = DONE;
      DONE:    state_n = start ? RUN : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // handshake outputs are pure state decodes
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // datapath: latch on accept, iterate in RUN, publish result on the last round
  always_ff @(posedge clk) begin
    if (rst) begin
      v0        <= '0;
      v1        <= '0;
      sum       <= '0;
      key_q     <= '0;
      round_cnt <= '0;
      plaintext <= '0;
    end else if (accept) begin
      v0        <= ciphertext[63:32];
      v1        <= ciphertext[31:0];
      key_q     <= tea_key_t'(key);
      sum       <= SUM_INIT;
      round_cnt <= '0;
    end else if (state == RUN) begin
      v0        <= v0_n;
      v1        <= v1_n;
      sum       <= sum - DELTA;
      round_cnt <= round_cnt + CW'(1);
      if (last) begin
        plaintext <= {v0_n, v1_n};
        // the schedule must unwind exactly back to zero
        assert (sum - DELTA == 32'd0);
      end
    end
  end

endmodule

// File: tb/tb_tea_decrypt.sv
// Self-checking bench for tea_decrypt against a behavioural TEA model.
module tb_tea_decrypt;

  localparam logic [31:0] D  = 32'h9E3779B9;
  localparam int          NR = 32;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [63:0]  ciphertext, plaintext;
  logic [127:0] key;
  logic         busy, done;

  int n_cmp = 0;
  int n_err = 0;

  tea_decrypt dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .ciphertext (ciphertext),
    .key        (key),
    .plaintext  (plaintext),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_enc(input logic [63:0] pt, input logic [127:0] k);
    logic [31:0] a, b, s;
    a = pt[63:32]; b = pt[31:0]; s = 0;
    for (int i = 0; i < NR; i++) begin
      s = s + D;
      a = a + (((b << 4) + k[127:96]) ^ (b + s) ^ ((b >> 5) + k[95:64]));
      b = b + (((a << 4) + k[63:32]) ^ (a + s) ^ ((a >> 5) + k[31:0]));
    end
    return {a, b};
  endfunction

  function automatic logic [63:0] ref_dec(input logic [63:0] ct, input logic [127:0] k);
    logic [31:0] a, b, s;
    a = ct[63:32]; b = ct[31:0]; s = 0;
    for (int i = 0; i < NR; i++) s = s + D;
    for (int i = 0; i < NR; i++) begin
      b = b - (((a << 4) + k[63:32]) ^ (a + s) ^ ((a >> 5) + k[31:0]));
      a = a - (((b << 4) + k[127:96]) ^ (b + s) ^ ((b >> 5) + k[95:64]));
      s = s - D;
    end
    return {a, b};
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // drive one block; lat = edges from accept to done sample, bcnt = cycles busy was high
  task automatic run_block(input logic [63:0] ct, input logic [127:0] k,
                           output logic [63:0] pt, output int lat, output int bcnt);
    ciphertext = ct; key = k; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = -1; bcnt = 0;
    for (int c = 0; c < 80; c++) begin
      if (busy) bcnt++;
      if (done) begin lat = c; break; end
      @(posedge clk); #1;
    end
    pt = plaintext;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; ciphertext = rnd64(); key = rnd128();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; start = 1'b0;
    n_cmp++; if (plaintext !== 64'h0) begin n_err++; $display("FAIL reset_pt got=%h exp=0", plaintext); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_beats_start busy=%b exp=0", busy); end
  endtask

  task automatic test_kat();
    logic [63:0] pt; int lat, bc;
    run_block(64'h41EA3A0A_94BAA940, 128'h0, pt, lat, bc);
    n_cmp++; if (pt !== 64'h0) begin n_err++; $display("FAIL kat_pt got=%h exp=0", pt); end
    n_cmp++; if (lat !== NR) begin n_err++; $display("FAIL kat_latency got=%0d exp=%0d", lat, NR); end
    n_cmp++; if (bc !== NR) begin n_err++; $display("FAIL kat_busy got=%0d exp=%0d", bc, NR); end
    @(posedge clk); #1;
  endtask

  task automatic test_roundtrip();
    logic [63:0] pt, got; logic [127:0] k; int lat, bc;
    for (int i = 0; i < 1000; i++) begin
      pt = rnd64(); k = rnd128();
      if (i == 0) begin pt = '1; k = '1; end
      run_block(ref_enc(pt, k), k, got, lat, bc);
      n_cmp++; if (got !== pt) begin n_err++; $display("FAIL roundtrip_pt i=%0d got=%h exp=%h", i, got, pt); end
      n_cmp++; if (bc !== NR || lat !== NR) begin n_err++; $display("FAIL roundtrip_timing i=%0d busy=%0d lat=%0d exp=%0d", i, bc, lat, NR); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_busy_guard();
    logic [63:0] a, b, p1; logic [127:0] k; int nd, t1;
    a = rnd64(); b = rnd64(); k = rnd128();
    ciphertext = a; key = k; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 start = 1'b1; ciphertext = b; key = rnd128();
    @(posedge clk); #1 start = 1'b0;
    nd = 0; t1 = -1; p1 = '0;
    for (int c = 11; c < 90; c++) begin
      if (done) begin if (nd == 0) begin t1 = c; p1 = plaintext; end nd++; end
      @(posedge clk); #1;
    end
    n_cmp++; if (nd !== 1) begin n_err++; $display("FAIL guard_done_count got=%0d exp=1", nd); end
    n_cmp++; if (p1 !== ref_dec(a, k)) begin n_err++; $display("FAIL guard_pt got=%h exp=%h", p1, ref_dec(a, k)); end
    n_cmp++; if (t1 !== NR) begin n_err++; $display("FAIL guard_latency got=%0d exp=%0d", t1, NR); end
  endtask

  // DONE re-accepts a waiting start, so back-to-back blocks finish NR+1 edges apart
  task automatic test_back_to_back();
    logic [63:0] a, b, p1, p2; logic [127:0] k; int nd, t1, t2;
    a = rnd64(); b = rnd64(); k = rnd128();
    ciphertext = a; key = k; start = 1'b1;
    @(posedge clk); #1 ciphertext = b;
    nd = 0; t1 = -1; t2 = -1; p1 = '0; p2 = '0;
    for (int c = 0; c < 120 && nd < 2; c++) begin
      if (done) begin
        if (nd == 0) begin t1 = c; p1 = plaintext; end
        else begin t2 = c; p2 = plaintext; end
        nd++;
      end
      @(posedge clk); #1;
      if (nd >= 1) start = 1'b0;
    end
    start = 1'b0;
    n_cmp++; if (nd !== 2) begin n_err++; $display("FAIL b2b_done_count got=%0d exp=2", nd); end
    n_cmp++; if (p1 !== ref_dec(a, k)) begin n_err++; $display("FAIL b2b_pt_a got=%h exp=%h", p1, ref_dec(a, k)); end
    n_cmp++; if (p2 !== ref_dec(b, k)) begin n_err++; $display("FAIL b2b_pt_b got=%h exp=%h", p2, ref_dec(b, k)); end
    n_cmp++; if (t1 !== NR || t2 - t1 !== NR + 1) begin n_err++; $display("FAIL b2b_spacing t1=%0d gap=%0d exp=%0d/%0d", t1, t2 - t1, NR, NR + 1); end
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_midop_reset();
    logic [63:0] a, pt; logic [127:0] k; int nd, lat, bc;
    a = rnd64(); k = rnd128();
    ciphertext = a; key = k; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (17) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    n_cmp++; if (plaintext !== 64'h0) begin n_err++; $display("FAIL midrst_pt got=%h exp=0", plaintext); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    nd = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) nd++;
      @(posedge clk); #1;
    end
    n_cmp++; if (nd !== 0) begin n_err++; $display("FAIL midrst_no_done got=%0d exp=0", nd); end
    a = rnd64(); k = rnd128();
    run_block(a, k, pt, lat, bc);
    n_cmp++; if (pt !== ref_dec(a, k) || lat !== NR) begin n_err++; $display("FAIL midrst_restart got=%h lat=%0d exp=%h/%0d", pt, lat, ref_dec(a, k), NR); end
    @(posedge clk); #1;
  endtask

  task automatic test_input_stability();
    logic [63:0] a, pt; logic [127:0] k; int lat;
    a = rnd64(); k = rnd128();
    ciphertext = a; key = k; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = -1; pt = '0;
    for (int c = 0; c < 80; c++) begin
      if (done) begin lat = c; pt = plaintext; break; end
      ciphertext = rnd64(); key = rnd128();
      @(posedge clk); #1;
    end
    n_cmp++; if (pt !== ref_dec(a, k)) begin n_err++; $display("FAIL stability_pt got=%h exp=%h", pt, ref_dec(a, k)); end
    n_cmp++; if (lat !== NR) begin n_err++; $display("FAIL stability_latency got=%0d exp=%0d", lat, NR); end
    n_cmp++; if (plaintext !== pt) begin n_err++; $display("FAIL stability_hold got=%h exp=%h", plaintext, pt); end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; ciphertext = '0; key = '0;
    test_reset();
    test_kat();
    test_roundtrip();
    test_busy_guard();
    test_back_to_back();
    test_midop_reset();
    test_input_stability();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
